inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter PTR_W, default $clog2(DEPTH), giving the read/write pointer width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-005 flush  input  1  discard all entries (branch redirect / mispredict recovery).
REQ-006 enq_valid  input  1  fetch presents an instruction packet.
REQ-007 enq_pkt  input  fetch_pkt_t  {pc[31:0], inst[31:0]} from fetch.
REQ-008 enq_ready  output  1  queue can accept a packet this cycle.
REQ-009 deq_valid  output  1  head entry valid for decode.
REQ-010 deq_pkt  output  fetch_pkt_t  head entry contents.
REQ-011 deq_ready  input  1  decode consumes head this cycle.
REQ-012 count  output  PTR_W+1  current occupancy, 0..DEPTH.

Function
REQ-013 Enqueue SHALL occur on a clock edge when enq_valid && enq_ready && !flush; the packet is written at wptr and wptr increments.
REQ-014 Dequeue SHALL occur on a clock edge when deq_valid && deq_ready && !flush; rptr increments.
REQ-015 enq_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on deq_ready.
REQ-016 deq_valid SHALL equal (count != 0); deq_pkt SHALL be driven from the entry at rptr with no added register stage.
REQ-017 Latency: a packet enqueued into an empty queue SHALL appear on deq_valid/deq_pkt the cycle after the enqueue edge; there is no same-cycle bypass.
REQ-018 Simultaneous enqueue and dequeue when 0 < count < DEPTH SHALL both take effect, leaving count unchanged.
REQ-019 When full, an enqueue attempt SHALL be ignored (enq_ready=0) even if a dequeue occurs in the same cycle; the freed slot is usable on the next cycle.
REQ-020 When empty, a deq_ready assertion SHALL have no effect.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL be maintained as a separate register, or derived from pointers carrying an extra wrap bit, and SHALL always equal enqueues minus dequeues.
REQ-022 flush SHALL take priority over enqueue and dequeue in the same cycle: on that edge, wptr, rptr and count are set to 0, and enq_pkt is discarded.
REQ-023 In the cycle after a flush edge, deq_valid SHALL be 0 and enq_ready SHALL be 1.
REQ-024 Storage contents need not be cleared on flush or reset; only pointers and count define validity.
REQ-025 Outputs SHALL NOT be X while rst is deasserted, given known inputs; deq_pkt is don't-care when deq_valid=0.

Reset
REQ-026 On a clock edge with rst=0, the block SHALL set wptr=0, rptr=0 and count=0.
REQ-027 Reset output values SHALL be deq_valid=0, enq_ready=1 and count=0, from the first edge with rst=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries identically to flush and SHALL override flush, enqueue and dequeue.

Structure
REQ-029 fetch_pkt_t (pc, inst, 32 bits each) and the IQ_DEPTH default SHALL reside in the shared cpu types package used by fetch and decode.
REQ-030 Storage SHALL be one flop-based array of DEPTH x fetch_pkt_t inside inst_queue; no sub-module is required.
REQ-031 inst_queue SHALL be instantiated in cpu between fetch (producer) and decode (consumer).

Verification
REQ-032 Reset then idle: hold rst=0 for 2 cycles -> deq_valid=0, enq_ready=1, count=0.
REQ-033 Fill/drain: enqueue 8 packets with pc 0x6000_0000 step 4 and deq_ready=0 -> count=8, enq_ready=0; a 9th enqueue is dropped; then set deq_ready=1 -> pcs emerge in order 0x6000_0000..0x6000_001C, then deq_valid=0.
REQ-034 Wrap: repeat enqueue-5/dequeue-5 three times -> order preserved across pointer wrap and count returns to 0 each round.
REQ-035 Simultaneous: with count=3, assert enqueue and dequeue together for 10 cycles -> count stays 3 and output order matches input order.
REQ-036 Full plus dequeue: with count=8, assert deq_ready and enq_valid together -> that enqueue is rejected, count=7, and the next-cycle enqueue is accepted.
REQ-037 Flush collision: with count=5, assert flush, enq_valid and deq_ready together -> next cycle count=0, deq_valid=0; a following enqueue of pc 0x6000_0100 is the next output.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Types shared between fetch, the instruction queue and decode.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: flop-array FIFO with flush.
// Head entry is driven straight from storage; there is no enqueue-to-dequeue bypass.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  input  fetch_pkt_t       enq_pkt,
  output logic             enq_ready,
  output logic             deq_valid,
  output fetch_pkt_t       deq_pkt,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_queue: DEPTH must be a power of two and at least 2");
  end

  fetch_pkt_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   enq_fire, deq_fire;

  // Readiness comes only from registered occupancy, so enq_ready never sees deq_ready.
  assign enq_ready = (cnt_q != CNT_W'(DEPTH));
  assign deq_valid = (cnt_q != '0);
  assign deq_pkt   = mem_q[rptr_q];
  assign count     = cnt_q;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq_fire) wptr_d = wptr_q + PTR_W'(1);
      if (deq_fire) rptr_d = rptr_q + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is never cleared; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rst && enq_fire) mem_q[wptr_q] <= enq_pkt;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed table, corner sequences, random vs queue model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  fetch_pkt_t       enq_pkt = '0;
  logic             enq_ready;
  logic             deq_valid;
  fetch_pkt_t       deq_pkt;
  logic             deq_ready = 1'b0;
  logic [PTR_W:0]   count;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_pkt   (enq_pkt),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_pkt   (deq_pkt),
    .deq_ready (deq_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  fetch_pkt_t model_q [$];

  typedef struct {
    logic        f;
    logic        ev;
    logic        dr;
    logic [31:0] pc;
    int          ecnt;
    logic        edv;
    logic        eer;
    logic [31:0] epc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic fetch_pkt_t mk(input logic [31:0] pc);
    fetch_pkt_t p;
    p.pc   = pc;
    p.inst = pc ^ 32'h5a5a_1234;
    return p;
  endfunction

  // One clock: drive inputs, advance, update the queue model, compare all outputs.
  task automatic cyc(input logic r, input logic f, input logic ev, input logic dr,
                     input logic [31:0] pc);
    fetch_pkt_t p;
    bit do_enq, do_deq;
    p = mk(pc);
    rst = r; flush = f; enq_valid = ev; deq_ready = dr; enq_pkt = p;
    @(posedge clk);
    if (!r || f) begin
      model_q.delete();
    end else begin
      do_enq = ev && (model_q.size() < DEPTH);
      do_deq = dr && (model_q.size() > 0);
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(p);
    end
    #1;
    chk("count", 64'(count), 64'(model_q.size()));
    chk("deq_valid", 64'(deq_valid), 64'(model_q.size() != 0));
    chk("enq_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
    if (model_q.size() != 0) chk("deq_pkt", 64'(deq_pkt), 64'(model_q[0]));
  endtask

  initial begin
    vec_t vecs [8];
    logic [31:0] base;

    // reset then idle
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);

    vecs[0] = '{0, 1, 0, 32'h6000_0000, 1, 1, 1, 32'h6000_0000};
    vecs[1] = '{0, 1, 1, 32'h6000_0004, 1, 1, 1, 32'h6000_0004};
    vecs[2] = '{0, 0, 1, 32'h0,         0, 0, 1, 32'h0};
    vecs[3] = '{0, 0, 1, 32'h0,         0, 0, 1, 32'h0};
    vecs[4] = '{1, 1, 0, 32'h6000_0008, 0, 0, 1, 32'h0};
    vecs[5] = '{0, 1, 0, 32'h6000_000C, 1, 1, 1, 32'h6000_000C};
    vecs[6] = '{0, 1, 0, 32'h6000_0010, 2, 1, 1, 32'h6000_000C};
    vecs[7] = '{1, 0, 1, 32'h0,         0, 0, 1, 32'h0};
    foreach (vecs[i]) begin
      cyc(1, vecs[i].f, vecs[i].ev, vecs[i].dr, vecs[i].pc);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ecnt));
      chk($sformatf("vec%0d_deq_valid", i), 64'(deq_valid), 64'(vecs[i].edv));
      chk($sformatf("vec%0d_enq_ready", i), 64'(enq_ready), 64'(vecs[i].eer));
      if (vecs[i].edv) chk($sformatf("vec%0d_pc", i), 64'(deq_pkt.pc), 64'(vecs[i].epc));
    end

    // fill / drain with a dropped ninth enqueue
    base = 32'h6000_0000;
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, base + 32'(4 * i));
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_enq_ready", 64'(enq_ready), 64'd0);
    cyc(1, 0, 1, 0, 32'h6000_0020);
    chk("drop9_count", 64'(count), 64'd8);
    chk("drain_head0", 64'(deq_pkt.pc), 64'(base));
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 1, 0);
      if (i < 8) chk($sformatf("drain_head%0d", i), 64'(deq_pkt.pc), 64'(base + 32'(4 * i)));
    end
    chk("drain_deq_valid", 64'(deq_valid), 64'd0);

    // wrap: three rounds of enqueue-5 / dequeue-5
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 32'h6100_0000 + 32'(r * 64 + i * 4));
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("wrap%0d_pc%0d", r, i), 64'(deq_pkt.pc), 64'(32'h6100_0000 + 32'(r * 64 + i * 4)));
        cyc(1, 0, 0, 1, 0);
      end
      chk($sformatf("wrap%0d_count", r), 64'(count), 64'd0);
    end

    // simultaneous enqueue/dequeue at count=3
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 32'h6200_0000 + 32'(4 * i));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("simul_pc%0d", i), 64'(deq_pkt.pc), 64'(32'h6200_0000 + 32'(4 * i)));
      cyc(1, 0, 1, 1, 32'h6200_0000 + 32'(4 * (i + 3)));
      chk($sformatf("simul_count%0d", i), 64'(count), 64'd3);
    end
    cyc(1, 1, 0, 0, 0);

    // full plus dequeue: enqueue rejected, freed slot usable next cycle
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 32'h6300_0000 + 32'(4 * i));
    cyc(1, 0, 1, 1, 32'h6300_0F00);
    chk("fulldeq_count", 64'(count), 64'd7);
    cyc(1, 0, 1, 0, 32'h6300_0F04);
    chk("fulldeq_next_count", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0);

    // flush colliding with enqueue and dequeue at count=5
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 32'h6400_0000 + 32'(4 * i));
    cyc(1, 1, 1, 1, 32'h6400_0FFC);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_deq_valid", 64'(deq_valid), 64'd0);
    chk("flush_enq_ready", 64'(enq_ready), 64'd1);
    cyc(1, 0, 1, 0, 32'h6000_0100);
    chk("postflush_pc", 64'(deq_pkt.pc), 64'h6000_0100);

    // reset mid-operation overrides everything
    cyc(1, 0, 1, 0, 32'h6500_0000);
    cyc(0, 0, 1, 1, 32'h6500_0004);
    chk("midrst_count", 64'(count), 64'd0);

    // randomized against the queue model; phases bias toward full and toward empty
    for (int i = 0; i < 3000; i++) begin
      logic r, f, ev, dr;
      r  = ($urandom_range(0, 299) != 0);
      f  = ($urandom_range(0, 39) == 0);
      ev = (i % 1000 < 500) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
      dr = (i % 1000 < 500) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8);
      cyc(r, f, ev, dr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
